slavefifo_stream_in_gen: RTL and testbench

Parametrised successor to the single-mode stream-IN writer. It drives the FX3 slave-FIFO write interface from a selectable test-pattern generator. Supports any bus width, selectable data patterns, and short packets closed with PKTEND. It sits beside the loopback/stream-OUT engines and is muxed onto the GPIF-II data bus by the top-level mode selector.

---
 rtl/slavefifo_pkg.sv | 40 ++++
 rtl/slavefifo_stream_in_gen_if.sv | 46 ++++
 rtl/slavefifo_pattern_gen.sv | 73 +++++++
 rtl/slavefifo_stream_in_gen.sv | 180 ++++++++++++++++++
 tb/tb_slavefifo_stream_in_gen.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/slavefifo_pkg.sv
// Shared definitions for the FX3 slave-FIFO stream-IN generator.
//   - FSM state encoding (3-bit)
//   - pattern_sel codes
//   - pattern seed constants (truncated to DATA_W by users)
//   - statistics counter widths (only with SLAVEFIFO_STREAM_IN_STATS_EN)
package slavefifo_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_FLAGB = 3'd1,
    ST_WRITE      = 3'd2,
    ST_WR_DELAY   = 3'd3,
    ST_PKTEND     = 3'd4
  } state_e;

  localparam int unsigned PAT_SEL_W = 2;

  localparam logic [PAT_SEL_W-1:0] PAT_COUNTER = 2'd0;
  localparam logic [PAT_SEL_W-1:0] PAT_WALK    = 2'd1;
  localparam logic [PAT_SEL_W-1:0] PAT_ALT     = 2'd2;
  localparam logic [PAT_SEL_W-1:0] PAT_ONES    = 2'd3;

  localparam logic [31:0] SEED_COUNTER = 32'h0000_0000;
  localparam logic [31:0] SEED_WALK    = 32'h0000_0001;
  localparam logic [31:0] SEED_ALT     = 32'h5555_5555;
  localparam logic [31:0] SEED_ONES    = 32'hFFFF_FFFF;

`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
  localparam int unsigned TOTAL_WORDS_W = 32;
  localparam int unsigned TOTAL_PKTS_W  = 16;
`endif

  // True in the states that drive slwr_n low.
  function automatic logic is_write_state(input state_e s);
    return (s == ST_WRITE) || (s == ST_WR_DELAY);
  endfunction

endpackage

// File: rtl/slavefifo_stream_in_gen_if.sv
// Slave-FIFO stream-IN bus between the generator and its environment.
// Optional macro: SLAVEFIFO_STREAM_IN_STATS_EN adds total_words/total_pkts.
//   enable, pattern_sel, pkt_words, flaga_d, flagb_d : environment -> generator
//   slwr_n, pktend_n, data_out, busy (+ stats)        : generator -> environment
// modport master: generator side; modport slave: environment side.
interface slavefifo_stream_in_gen_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PKT_W  = 16
) ();

  logic              enable;
  logic [1:0]        pattern_sel;
  logic [PKT_W-1:0]  pkt_words;
  logic              flaga_d;
  logic              flagb_d;
  logic              slwr_n;
  logic              pktend_n;
  logic [DATA_W-1:0] data_out;
  logic              busy;

`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
  logic [slavefifo_pkg::TOTAL_WORDS_W-1:0] total_words;
  logic [slavefifo_pkg::TOTAL_PKTS_W-1:0]  total_pkts;

  modport master (
    input  enable, pattern_sel, pkt_words, flaga_d, flagb_d,
    output slwr_n, pktend_n, data_out, busy, total_words, total_pkts
  );

  modport slave (
    output enable, pattern_sel, pkt_words, flaga_d, flagb_d,
    input  slwr_n, pktend_n, data_out, busy, total_words, total_pkts
  );
`else
  modport master (
    input  enable, pattern_sel, pkt_words, flaga_d, flagb_d,
    output slwr_n, pktend_n, data_out, busy
  );

  modport slave (
    output enable, pattern_sel, pkt_words, flaga_d, flagb_d,
    input  slwr_n, pktend_n, data_out, busy
  );
`endif

endinterface

// File: rtl/slavefifo_pattern_gen.sv
// Test-pattern register for the stream-IN generator.
//   clk, rst  : clock, async active-high reset (data -> 0)
//   load_seed : load the seed of pattern 'sel' (wins over advance)
//   advance   : step the pattern once (one written word)
//   sel       : pattern code (counter / walking ones / alternating / all ones)
//   data      : current pattern word
module slavefifo_pattern_gen
  import slavefifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_seed,
  input  logic                 advance,
  input  logic [PAT_SEL_W-1:0] sel,
  output logic [DATA_W-1:0]    data
);

  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] seed_c;
  logic [DATA_W-1:0] step_c;

  // Seed and single-step successor for the selected pattern.
  always_comb begin
    seed_c = DATA_W'(SEED_COUNTER);
    step_c = data_q;
    case (sel)
      PAT_COUNTER: begin
        seed_c = DATA_W'(SEED_COUNTER);
        step_c = data_q + DATA_W'(1);
      end
      PAT_WALK: begin
        seed_c = DATA_W'(SEED_WALK);
        step_c = {data_q[DATA_W-2:0], data_q[DATA_W-1]};
      end
      PAT_ALT: begin
        seed_c = DATA_W'(SEED_ALT);
        step_c = ~data_q;
      end
      PAT_ONES: begin
        seed_c = DATA_W'(SEED_ONES);
        step_c = data_q;
      end
      default: begin
        seed_c = DATA_W'(SEED_COUNTER);
        step_c = data_q;
      end
    endcase
  end

  // Seed reload has priority over stepping.
  always_comb begin
    data_d = data_q;
    if (load_seed) begin
      data_d = seed_c;
    end else if (advance) begin
      data_d = step_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data = data_q;

endmodule

// File: rtl/slavefifo_stream_in_gen.sv
// FX3 slave-FIFO stream-IN writer driven by a selectable test pattern.
// Optional macro: SLAVEFIFO_STREAM_IN_STATS_EN adds total_words/total_pkts.
//   clk_100 : 100 MHz system clock
//   reset   : asynchronous active-high reset
//   bus     : slave-FIFO stream-IN interface (master modport)
//             enable, pattern_sel, pkt_words, flaga_d, flagb_d in;
//             slwr_n, pktend_n, data_out, busy (+ stats) out
module slavefifo_stream_in_gen
  import slavefifo_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PKT_W  = 16
) (
  input  logic                       clk_100,
  input  logic                       reset,
  slavefifo_stream_in_gen_if.master  bus
);

  state_e               state_q, state_d;
  logic [PAT_SEL_W-1:0] sel_q, sel_d;
  logic [PKT_W-1:0]     n_q, n_d;
  logic [PKT_W-1:0]     cnt_q, cnt_d;
  logic                 fresh_q, fresh_d;
  logic                 slwr_n_q, slwr_n_d;
  logic                 pktend_n_q, pktend_n_d;
  logic                 busy_q, busy_d;

  logic                 writing_c;
  logic                 last_word_c;
  logic                 start_c;
  logic                 load_seed_c;
  logic [PAT_SEL_W-1:0] pat_sel_c;

`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
  logic [TOTAL_WORDS_W-1:0] total_words_q, total_words_d;
  logic [TOTAL_PKTS_W-1:0]  total_pkts_q, total_pkts_d;
`endif

  // Next-state, counters and registered output decode.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    fresh_d    = fresh_q;

    writing_c   = is_write_state(state_q);
    // cnt_q holds words already written, so the current word is cnt_q+1.
    last_word_c = (n_q != '0) && (cnt_q == (n_q - PKT_W'(1)));
    start_c     = (state_q == ST_IDLE) && bus.enable && bus.flaga_d;

    unique case (state_q)
      ST_IDLE: begin
        if (start_c) begin
          state_d = ST_WAIT_FLAGB;
          sel_d   = bus.pattern_sel;
          n_d     = bus.pkt_words;
        end
      end
      ST_WAIT_FLAGB: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (bus.flagb_d) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!bus.enable) begin
          state_d = ST_IDLE;
        end else if (last_word_c) begin
          state_d = ST_PKTEND;
        end else if (!bus.flagb_d) begin
          state_d = ST_WR_DELAY;
        end
      end
      ST_WR_DELAY: begin
        state_d = last_word_c ? ST_PKTEND : ST_IDLE;
      end
      ST_PKTEND: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Packet word counter: survives IDLE gaps, saturates in continuous mode.
    if (!bus.enable) begin
      cnt_d = '0;
    end else if (state_q == ST_PKTEND) begin
      cnt_d = '0;
    end else if (writing_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + PKT_W'(1);
    end

    // After reset or enable=0 the next start must reseed the pattern.
    if (!bus.enable) begin
      fresh_d = 1'b1;
    end else if (start_c) begin
      fresh_d = 1'b0;
    end

    load_seed_c = !bus.enable || (start_c && fresh_q);
    pat_sel_c   = (state_q == ST_IDLE) ? bus.pattern_sel : sel_q;

    // Outputs are decoded from the next state so they align with state_q.
    slwr_n_d   = !is_write_state(state_d);
    pktend_n_d = (state_d != ST_PKTEND);
    busy_d     = (state_d != ST_IDLE);

`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
    total_words_d = total_words_q;
    total_pkts_d  = total_pkts_q;
    if (!bus.enable) begin
      total_words_d = '0;
      total_pkts_d  = '0;
    end else begin
      if (writing_c) begin
        total_words_d = total_words_q + TOTAL_WORDS_W'(1);
      end
      if (state_q == ST_PKTEND) begin
        total_pkts_d = total_pkts_q + TOTAL_PKTS_W'(1);
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_100 or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sel_q         <= PAT_COUNTER;
      n_q           <= '0;
      cnt_q         <= '0;
      fresh_q       <= 1'b1;
      slwr_n_q      <= 1'b1;
      pktend_n_q    <= 1'b1;
      busy_q        <= 1'b0;
`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
      total_words_q <= '0;
      total_pkts_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      n_q           <= n_d;
      cnt_q         <= cnt_d;
      fresh_q       <= fresh_d;
      slwr_n_q      <= slwr_n_d;
      pktend_n_q    <= pktend_n_d;
      busy_q        <= busy_d;
`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
      total_words_q <= total_words_d;
      total_pkts_q  <= total_pkts_d;
`endif
    end
  end

  // Pattern register steps on every written word.
  slavefifo_pattern_gen #(
    .DATA_W (DATA_W)
  ) u_pattern_gen (
    .clk       (clk_100),
    .rst       (reset),
    .load_seed (load_seed_c),
    .advance   (writing_c),
    .sel       (pat_sel_c),
    .data      (bus.data_out)
  );

  assign bus.slwr_n   = slwr_n_q;
  assign bus.pktend_n = pktend_n_q;
  assign bus.busy     = busy_q;

`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
  assign bus.total_words = total_words_q;
  assign bus.total_pkts  = total_pkts_q;
`endif

endmodule

// File: tb/tb_slavefifo_stream_in_gen.sv
// Directed bench for slavefifo_stream_in_gen (DATA_W=8, PKT_W=8).
// Stats outputs are checked when SLAVEFIFO_STREAM_IN_STATS_EN is defined.
module tb_slavefifo_stream_in_gen;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PKT_W  = 8;

  logic clk_100;
  logic reset;
  int   errors;
  int   checks;

  slavefifo_stream_in_gen_if #(.DATA_W(DATA_W), .PKT_W(PKT_W)) bus ();

  slavefifo_stream_in_gen #(
    .DATA_W (DATA_W),
    .PKT_W  (PKT_W)
  ) dut (
    .clk_100 (clk_100),
    .reset   (reset),
    .bus     (bus)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, then check strobes and (if e_data >= 0) data.
  task automatic cyc(input string tag, input logic e_slwr, input logic e_pkt, input int e_data);
    @(posedge clk_100);
    #1;
    chk({tag, "_slwr_n"}, 32'(bus.slwr_n), 32'(e_slwr));
    chk({tag, "_pktend_n"}, 32'(bus.pktend_n), 32'(e_pkt));
    if (e_data >= 0) begin
      chk({tag, "_data"}, 32'(bus.data_out), 32'(e_data));
    end
  endtask

  logic [7:0] walk;

  initial begin
    errors          = 0;
    checks          = 0;
    reset           = 1'b1;
    bus.enable      = 1'b0;
    bus.flaga_d     = 1'b0;
    bus.flagb_d     = 1'b0;
    bus.pattern_sel = 2'd0;
    bus.pkt_words   = '0;

    // Reset values
    repeat (3) @(posedge clk_100);
    #1;
    chk("rst_slwr_n", 32'(bus.slwr_n), 32'd1);
    chk("rst_pktend_n", 32'(bus.pktend_n), 32'd1);
    chk("rst_data", 32'(bus.data_out), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
    chk("rst_total_words", bus.total_words, 32'd0);
    chk("rst_total_pkts", 32'(bus.total_pkts), 32'd0);
`endif
    reset = 1'b0;

    // 1: continuous counter stream
    bus.enable  = 1'b1;
    bus.flaga_d = 1'b1;
    bus.flagb_d = 1'b1;
    cyc("t1_wait", 1'b1, 1'b1, -1);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    cyc("t1_w0", 1'b0, 1'b1, 0);
    cyc("t1_w1", 1'b0, 1'b1, 1);
    cyc("t1_w2", 1'b0, 1'b1, 2);
    cyc("t1_w3", 1'b0, 1'b1, 3);

    // 2: flagb drop gives one delay word, then resume without skip
    bus.flagb_d = 1'b0;
    cyc("t2_delay", 1'b0, 1'b1, 4);
    bus.flagb_d = 1'b1;
    cyc("t2_idle", 1'b1, 1'b1, -1);
    chk("t2_idle_busy", 32'(bus.busy), 32'd0);
    cyc("t2_wait", 1'b1, 1'b1, -1);
    cyc("t2_resume", 1'b0, 1'b1, 5);
    cyc("t2_next", 1'b0, 1'b1, 6);

    // 3: 5-word packets
    bus.enable = 1'b0;
    cyc("t3_stop", 1'b1, 1'b1, -1);
    bus.pkt_words = 8'd5;
    bus.enable    = 1'b1;
    cyc("t3_wait", 1'b1, 1'b1, -1);
    for (int i = 0; i < 5; i++) cyc("t3_word", 1'b0, 1'b1, i);
    cyc("t3_pktend", 1'b1, 1'b0, -1);
    cyc("t3_idle", 1'b1, 1'b1, -1);
    chk("t3_idle_busy", 32'(bus.busy), 32'd0);
    cyc("t3_wait2", 1'b1, 1'b1, -1);
    cyc("t3_newpkt", 1'b0, 1'b1, 5);

    // 4: 8-word packet split across a buffer switch
    bus.enable = 1'b0;
    cyc("t4_stop", 1'b1, 1'b1, -1);
    bus.pkt_words = 8'd8;
    bus.enable    = 1'b1;
    cyc("t4_wait", 1'b1, 1'b1, -1);
    cyc("t4_w0", 1'b0, 1'b1, 0);
    cyc("t4_w1", 1'b0, 1'b1, 1);
    cyc("t4_w2", 1'b0, 1'b1, 2);
    bus.flagb_d = 1'b0;
    cyc("t4_delay", 1'b0, 1'b1, 3);
    bus.flagb_d = 1'b1;
    cyc("t4_idle", 1'b1, 1'b1, -1);
    cyc("t4_wait2", 1'b1, 1'b1, -1);
    for (int i = 4; i < 8; i++) cyc("t4_word", 1'b0, 1'b1, i);
    cyc("t4_pktend", 1'b1, 1'b0, -1);
    cyc("t4_idle2", 1'b1, 1'b1, -1);
`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
    chk("t4_total_words", bus.total_words, 32'd8);
    chk("t4_total_pkts", 32'(bus.total_pkts), 32'd1);
`endif

    // 5: walking ones, then alternating
    bus.enable      = 1'b0;
    bus.pattern_sel = 2'd1;
    bus.pkt_words   = '0;
    cyc("t5_seed", 1'b1, 1'b1, 8'h01);
`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
    chk("t5_total_words_clr", bus.total_words, 32'd0);
    chk("t5_total_pkts_clr", 32'(bus.total_pkts), 32'd0);
`endif
    bus.enable = 1'b1;
    cyc("t5_wait", 1'b1, 1'b1, -1);
    walk = 8'h01;
    for (int i = 0; i < 9; i++) begin
      cyc("t5_walk", 1'b0, 1'b1, int'(walk));
      walk = {walk[6:0], walk[7]};
    end
    bus.enable      = 1'b0;
    bus.pattern_sel = 2'd2;
    cyc("t5_stop", 1'b1, 1'b1, -1);
    bus.enable = 1'b1;
    cyc("t5_wait2", 1'b1, 1'b1, -1);
    cyc("t5_alt0", 1'b0, 1'b1, 8'h55);
    cyc("t5_alt1", 1'b0, 1'b1, 8'hAA);
    cyc("t5_alt2", 1'b0, 1'b1, 8'h55);

    // 6: enable drop mid-WRITE, no PKTEND, restart from seed
    bus.enable      = 1'b0;
    bus.pattern_sel = 2'd0;
    cyc("t6_stop", 1'b1, 1'b1, -1);
`ifdef SLAVEFIFO_STREAM_IN_STATS_EN
    chk("t6_total_words", bus.total_words, 32'd0);
`endif
    cyc("t6_nopkt", 1'b1, 1'b1, 0);
    bus.enable = 1'b1;
    cyc("t6_wait", 1'b1, 1'b1, -1);
    cyc("t6_restart", 1'b0, 1'b1, 0);
    cyc("t6_next", 1'b0, 1'b1, 1);

    // 7: single-word packet with flagb dropping on the final word
    bus.enable = 1'b0;
    cyc("t7_stop", 1'b1, 1'b1, -1);
    bus.pkt_words = 8'd1;
    bus.enable    = 1'b1;
    cyc("t7_wait", 1'b1, 1'b1, -1);
    cyc("t7_word", 1'b0, 1'b1, 0);
    bus.flagb_d = 1'b0;
    cyc("t7_pktend", 1'b1, 1'b0, 1);
    bus.flagb_d = 1'b1;
    cyc("t7_idle", 1'b1, 1'b1, -1);

    // 8: asynchronous reset mid-burst
    cyc("t8_wait", 1'b1, 1'b1, -1);
    cyc("t8_word", 1'b0, 1'b1, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("t8_rst_slwr_n", 32'(bus.slwr_n), 32'd1);
    chk("t8_rst_pktend_n", 32'(bus.pktend_n), 32'd1);
    chk("t8_rst_data", 32'(bus.data_out), 32'd0);
    chk("t8_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk_100);
    #1;
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
